pipeline_redirect_ctrl: RTL and testbench
=========================================

// Module: pipeline_redirect_ctrl
// PURPOSE
//  Central stall/flush/redirect controller for an N-stage in-order pipeline. Resolves per-stage stall and
//  flush requests, computes trap and trap-return targets, and drains outstanding memory ops before a trap
//  redirect. Sits beside the stage chain; emits per-stage stall/flush vectors and a registered redirect PC.
// PARAMETERS
//  NUM_STAGES     6   pipeline stages; index 0 = fetch (youngest), NUM_STAGES-1 = oldest (commit)
//  ADDR_WIDTH     32  PC / xtvec / xepc width
//  CAUSE_WIDTH    5   trap cause code width
//  DRAIN_TIMEOUT  256 max DRAIN cycles before forced redirect; 0 disables timeout
// PORTS
//  clk                 in   1                      clock
//  rst                 in   1                      synchronous reset, active high
//  stall_req           in   NUM_STAGES             per-stage stall request
//  flush_req           in   NUM_STAGES             per-stage redirect request (branch mispredict etc.)
//  flush_target        in   NUM_STAGES*ADDR_WIDTH  redirect PC per stage, slice i belongs to stage i
//  trap_valid          in   1                      trap accepted at commit
//  trap_is_interrupt   in   1                      trap is an interrupt
//  trap_code           in   CAUSE_WIDTH            cause code
//  next_priv           in   2                      privilege the trap enters (M=3, S=1, U=0)
//  trap_return_valid   in   1                      xRET at commit
//  trap_return_priv    in   2                      privilege whose xepc is used
//  mtvec/stvec/utvec   in   ADDR_WIDTH each        {base[ADDR_WIDTH-1:2], mode[1:0]}
//  mepc/sepc/uepc      in   ADDR_WIDTH each        trap return PCs
//  mem_idle            in   1                      no outstanding loads/stores
//  stall               out  NUM_STAGES             per-stage hold
//  flush               out  NUM_STAGES             per-stage invalidate
//  redirect_valid      out  1                      registered, 1-cycle pulse to fetch
//  redirect_pc         out  ADDR_WIDTH             registered target, held between pulses
//  busy                out  1                      state != IDLE
//  timeout_error       out  1                      sticky: DRAIN timed out
// BEHAVIOUR
//  - Reset (rst high at clk edge): state=IDLE, redirect_valid=0, redirect_pc=0, timeout_error=0, drain_cnt=0.
//    Reset overrides any in-flight DRAIN/REDIRECT. stall/flush are combinational from state+inputs.
//  - FSM IDLE/DRAIN/REDIRECT. Only IDLE accepts events; requests in DRAIN/REDIRECT are ignored.
//  - IDLE priority: trap_valid > trap_return_valid > oldest flush_req (highest index k).
//    trap/xRET: capture target; flush='1; -> REDIRECT if mem_idle else -> DRAIN (drain_cnt=0).
//    flush_req k: capture flush_target[k]; flush[i]=1 for i<k (stage k itself kept); -> REDIRECT.
//    none: stall[i] = OR(stall_req[j], j>=i); flush='0.
//  - Flush dominates stall per stage: stall[i]=0 wherever flush[i]=1.
//  - DRAIN: stall='1, flush='0 (held until redirect); drain_cnt++; -> REDIRECT when mem_idle, or when
//    DRAIN_TIMEOUT!=0 and drain_cnt==DRAIN_TIMEOUT-1 (set timeout_error, cleared only by rst).
//  - REDIRECT (exactly 1 cycle): flush='1, stall='0; -> IDLE. redirect_valid=1 this cycle, redirect_pc=captured.
//    Latency: event cycle T -> redirect_valid at T+1 (no drain) or cycle after mem_idle seen.
//  - Trap target: xtvec by next_priv (priv 2 -> 0). mode==01 && interrupt: {base+trap_code, 2'b00},
//    add zero-extended, modulo ADDR_WIDTH-2 bits (wraps); else {base, 2'b00} (mode 1x = direct).
//  - Trap-return target: xepc by trap_return_priv; priv 2 -> 0.
// STRUCTURE
//  - pipeline_ctrl_pkg: priv_t, ctrl_state_e {IDLE,DRAIN,REDIRECT}, tvec_t struct {base,mode},
//    function trap_vector(tvec_t, logic is_int, logic [CAUSE_WIDTH-1:0] code).
//  - Sub-module trap_target_sel (combinational xtvec/xepc mux + vectoring); FSM, stall/flush in top.
// TESTING
//  - stall_req=6'b000100, no flush -> stall=6'b000111, flush=0, busy=0.
//  - flush_req=6'b001010, targets[3]=0x100,[1]=0x200 -> flush=6'b000111 same cycle; next cycle
//    redirect_valid=1, redirect_pc=0x100; then IDLE.
//  - trap int, code 7, next_priv=M, mtvec=0x8000_0001, mem_idle=1 -> flush='1; next cycle redirect_pc=0x8000_001C.
//  - trap exc, mem_idle=0 for 5 cycles -> stall='1 for 5 cycles, redirect 1 cycle after mem_idle rises.
//  - DRAIN_TIMEOUT=4, mem_idle stuck 0 -> redirect after 4 DRAIN cycles, timeout_error stays 1 until rst.
//  - trap and flush_req[4] same cycle -> trap target wins; rst during DRAIN -> next cycle IDLE, outputs 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush/redirect controller.
// Trap vector arithmetic lives here so every user computes targets identically.
package pipeline_ctrl_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int CAUSE_WIDTH = 5;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_H = 2'd2,
    PRIV_M = 2'd3
  } priv_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-3:0] base;
    logic [1:0]            mode;
  } tvec_t;

  // Vectored mode only applies to interrupts; the base offset wraps inside the base field.
  function automatic logic [ADDR_WIDTH-1:0] trap_vector(tvec_t tvec, logic is_int,
                                                        logic [CAUSE_WIDTH-1:0] code);
    logic [ADDR_WIDTH-3:0] base;
    base = tvec.base;
    if (tvec.mode == 2'b01 && is_int) begin
      base = tvec.base + (ADDR_WIDTH-2)'(code);
    end
    return {base, 2'b00};
  endfunction

endpackage

// File: rtl/pipeline_redirect_ctrl_if.sv
// Request/response bundle between the pipeline stages and the redirect controller.
// The pipeline side is the master; the controller is the slave.
interface pipeline_redirect_ctrl_if #(
  parameter int NUM_STAGES = 6
);
  import pipeline_ctrl_pkg::*;

  logic [NUM_STAGES-1:0]            stall_req;
  logic [NUM_STAGES-1:0]            flush_req;
  logic [NUM_STAGES*ADDR_WIDTH-1:0] flush_target;
  logic                             trap_valid;
  logic                             trap_is_interrupt;
  logic [CAUSE_WIDTH-1:0]           trap_code;
  logic [1:0]                       next_priv;
  logic                             trap_return_valid;
  logic [1:0]                       trap_return_priv;
  logic [ADDR_WIDTH-1:0]            mtvec;
  logic [ADDR_WIDTH-1:0]            stvec;
  logic [ADDR_WIDTH-1:0]            utvec;
  logic [ADDR_WIDTH-1:0]            mepc;
  logic [ADDR_WIDTH-1:0]            sepc;
  logic [ADDR_WIDTH-1:0]            uepc;
  logic                             mem_idle;

  logic [NUM_STAGES-1:0]            stall;
  logic [NUM_STAGES-1:0]            flush;
  logic                             redirect_valid;
  logic [ADDR_WIDTH-1:0]            redirect_pc;
  logic                             busy;
  logic                             timeout_error;

  modport master (
    output stall_req, flush_req, flush_target, trap_valid, trap_is_interrupt, trap_code,
           next_priv, trap_return_valid, trap_return_priv, mtvec, stvec, utvec,
           mepc, sepc, uepc, mem_idle,
    input  stall, flush, redirect_valid, redirect_pc, busy, timeout_error
  );

  modport slave (
    input  stall_req, flush_req, flush_target, trap_valid, trap_is_interrupt, trap_code,
           next_priv, trap_return_valid, trap_return_priv, mtvec, stvec, utvec,
           mepc, sepc, uepc, mem_idle,
    output stall, flush, redirect_valid, redirect_pc, busy, timeout_error
  );

endinterface

// File: rtl/trap_target_sel.sv
// Combinational selection of the trap vector and trap-return PC by privilege level.
// The reserved privilege encoding (2) falls back to the user-level registers.
module trap_target_sel
  import pipeline_ctrl_pkg::*;
(
  input  logic                   trap_is_interrupt_i,
  input  logic [CAUSE_WIDTH-1:0] trap_code_i,
  input  logic [1:0]             next_priv_i,
  input  logic [1:0]             trap_return_priv_i,
  input  logic [ADDR_WIDTH-1:0]  mtvec_i,
  input  logic [ADDR_WIDTH-1:0]  stvec_i,
  input  logic [ADDR_WIDTH-1:0]  utvec_i,
  input  logic [ADDR_WIDTH-1:0]  mepc_i,
  input  logic [ADDR_WIDTH-1:0]  sepc_i,
  input  logic [ADDR_WIDTH-1:0]  uepc_i,
  output logic [ADDR_WIDTH-1:0]  trap_pc_o,
  output logic [ADDR_WIDTH-1:0]  xret_pc_o
);

  tvec_t tvec_sel;

  // NOTE: every output of a combinational block gets a value on every path, else a latch is inferred.
  always_comb begin
    case (next_priv_i)
      PRIV_M:  tvec_sel = tvec_t'(mtvec_i);
      PRIV_S:  tvec_sel = tvec_t'(stvec_i);
      default: tvec_sel = tvec_t'(utvec_i);
    endcase

    case (trap_return_priv_i)
      PRIV_M:  xret_pc_o = mepc_i;
      PRIV_S:  xret_pc_o = sepc_i;
      default: xret_pc_o = uepc_i;
    endcase
  end

  assign trap_pc_o = trap_vector(tvec_sel, trap_is_interrupt_i, trap_code_i);

endmodule

// File: rtl/pipeline_redirect_ctrl.sv
// Central stall/flush/redirect controller: resolves stage requests, drains memory before
// trap redirects and issues a registered one-cycle redirect pulse to fetch.
module pipeline_redirect_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = 6,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  pipeline_redirect_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_DRAIN    = DRAIN;
  localparam logic [1:0] ST_REDIRECT = REDIRECT;

  localparam int              CNT_W      = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam bit              TIMEOUT_EN = (DRAIN_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = (DRAIN_TIMEOUT > 0) ? CNT_W'(DRAIN_TIMEOUT - 1) : '0;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic                  timeout_error_q, timeout_error_d;

  logic [ADDR_WIDTH-1:0] trap_pc, xret_pc, flush_pc;
  logic [NUM_STAGES-1:0] stall_chain, older_flush;
  logic [NUM_STAGES-1:0] stall_v, flush_v;
  logic                  stall_acc, flush_seen;

  trap_target_sel u_trap_target_sel (
    .trap_is_interrupt_i (bus.trap_is_interrupt),
    .trap_code_i         (bus.trap_code),
    .next_priv_i         (bus.next_priv),
    .trap_return_priv_i  (bus.trap_return_priv),
    .mtvec_i             (bus.mtvec),
    .stvec_i             (bus.stvec),
    .utvec_i             (bus.utvec),
    .mepc_i              (bus.mepc),
    .sepc_i              (bus.sepc),
    .uepc_i              (bus.uepc),
    .trap_pc_o           (trap_pc),
    .xret_pc_o           (xret_pc)
  );

  // Walk from the oldest stage down: a stall holds everything younger, and a flush
  // request kills only the stages younger than the oldest requester.
  always_comb begin
    stall_chain = '0;
    older_flush = '0;
    stall_acc   = 1'b0;
    flush_seen  = 1'b0;
    flush_pc    = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      stall_acc      = stall_acc | bus.stall_req[i];
      stall_chain[i] = stall_acc;
      older_flush[i] = flush_seen;
      flush_seen     = flush_seen | bus.flush_req[i];
    end
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (bus.flush_req[i]) flush_pc = bus.flush_target[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    state_d          = state_q;
    drain_cnt_d      = drain_cnt_q;
    target_d         = target_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = 1'b0;
    timeout_error_d  = timeout_error_q;
    stall_v          = '0;
    flush_v          = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.trap_valid || bus.trap_return_valid) begin
          target_d = bus.trap_valid ? trap_pc : xret_pc;
          flush_v  = '1;
          if (bus.mem_idle) begin
            state_d = ST_REDIRECT;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end else if (|bus.flush_req) begin
          target_d = flush_pc;
          flush_v  = older_flush;
          state_d  = ST_REDIRECT;
        end
        stall_v = stall_chain & ~flush_v;
      end

      ST_DRAIN: begin
        stall_v     = '1;
        drain_cnt_d = drain_cnt_q + CNT_W'(1);
        if (bus.mem_idle) begin
          state_d = ST_REDIRECT;
        end else if (TIMEOUT_EN && drain_cnt_q == CNT_LAST) begin
          state_d         = ST_REDIRECT;
          timeout_error_d = 1'b1;
        end
      end

      ST_REDIRECT: begin
        flush_v = '1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // The redirect PC only moves together with its pulse, so fetch sees a stable value otherwise.
    if (state_d == ST_REDIRECT) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = target_d;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      drain_cnt_q      <= '0;
      target_q         <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      timeout_error_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      drain_cnt_q      <= drain_cnt_d;
      target_q         <= target_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      timeout_error_q  <= timeout_error_d;
    end
  end

  assign bus.stall          = stall_v;
  assign bus.flush          = flush_v;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.timeout_error  = timeout_error_q;

endmodule

// File: tb/tb_pipeline_redirect_ctrl.sv
// Self-checking bench: two controllers (drain timeout 256 and 4) share one stimulus stream and
// are compared every cycle against a behavioural model, with directed literal expectations first.
module tb_pipeline_redirect_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int NS    = 6;
  localparam int AW    = ADDR_WIDTH;
  localparam int TMO_A = 256;
  localparam int TMO_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NS-1:0]        stall_req, flush_req;
  logic [NS*AW-1:0]     flush_target;
  logic                 trap_valid, trap_is_interrupt, trap_return_valid, mem_idle;
  logic [CAUSE_WIDTH-1:0] trap_code;
  logic [1:0]           next_priv, trap_return_priv;
  logic [AW-1:0]        mtvec, stvec, utvec, mepc, sepc, uepc;

  logic [NS-1:0] o_stall [2];
  logic [NS-1:0] o_flush [2];
  logic          o_rv    [2];
  logic [AW-1:0] o_pc    [2];
  logic          o_busy  [2];
  logic          o_terr  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipeline_redirect_ctrl_if #(.NUM_STAGES(NS)) bus ();
    assign bus.stall_req         = stall_req;
    assign bus.flush_req         = flush_req;
    assign bus.flush_target      = flush_target;
    assign bus.trap_valid        = trap_valid;
    assign bus.trap_is_interrupt = trap_is_interrupt;
    assign bus.trap_code         = trap_code;
    assign bus.next_priv         = next_priv;
    assign bus.trap_return_valid = trap_return_valid;
    assign bus.trap_return_priv  = trap_return_priv;
    assign bus.mtvec             = mtvec;
    assign bus.stvec             = stvec;
    assign bus.utvec             = utvec;
    assign bus.mepc              = mepc;
    assign bus.sepc              = sepc;
    assign bus.uepc              = uepc;
    assign bus.mem_idle          = mem_idle;
    assign o_stall[g] = bus.stall;
    assign o_flush[g] = bus.flush;
    assign o_rv[g]    = bus.redirect_valid;
    assign o_pc[g]    = bus.redirect_pc;
    assign o_busy[g]  = bus.busy;
    assign o_terr[g]  = bus.timeout_error;

    pipeline_redirect_ctrl #(
      .NUM_STAGES    (NS),
      .DRAIN_TIMEOUT ((g == 0) ? TMO_A : TMO_B)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: what each controller is doing and what its registered outputs hold.
  typedef struct {
    bit            draining;
    int unsigned   drain_age;
    bit            redirecting;
    logic [AW-1:0] tgt;
    logic          rv;
    logic [AW-1:0] pc;
    logic          terr;
  } model_t;

  model_t m [2];
  bit     model_on = 1'b0;

  function automatic int unsigned tmo_of(input int d);
    return (d == 0) ? TMO_A : TMO_B;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.draining = 1'b0; r.drain_age = 0; r.redirecting = 1'b0;
    r.tgt = '0; r.rv = 1'b0; r.pc = '0; r.terr = 1'b0;
    return r;
  endfunction

  function automatic logic [AW-1:0] model_trap_pc();
    logic [AW-1:0] v;
    v = (next_priv == 2'd3) ? mtvec : (next_priv == 2'd1) ? stvec : utvec;
    if (v[1:0] == 2'b01 && trap_is_interrupt)
      return (v & 32'hFFFF_FFFC) + {25'd0, trap_code, 2'b00};
    return v & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [AW-1:0] model_xret_pc();
    return (trap_return_priv == 2'd3) ? mepc : (trap_return_priv == 2'd1) ? sepc : uepc;
  endfunction

  function automatic int oldest_flush();
    int k = -1;
    for (int i = 0; i < NS; i++) if (flush_req[i]) k = i;
    return k;
  endfunction

  function automatic void expect_comb(input model_t mm, output logic [NS-1:0] es,
                                      output logic [NS-1:0] ef);
    int k;
    es = '0;
    ef = '0;
    if (mm.redirecting) begin
      ef = '1;
    end else if (mm.draining) begin
      es = '1;
    end else begin
      k = oldest_flush();
      if (trap_valid || trap_return_valid) ef = '1;
      else if (k >= 0) ef = NS'((1 << k) - 1);
      for (int i = 0; i < NS; i++) es[i] = ((stall_req >> i) != 0) && !ef[i];
    end
  endfunction

  function automatic model_t model_next(input model_t mm, input int unsigned tmo);
    model_t n;
    int k;
    n = mm;
    n.rv = 1'b0;
    if (mm.redirecting) begin
      n.redirecting = 1'b0;
    end else if (mm.draining) begin
      if (mem_idle || (tmo != 0 && mm.drain_age + 1 == tmo)) begin
        if (!mem_idle) n.terr = 1'b1;
        n.draining = 1'b0; n.redirecting = 1'b1; n.rv = 1'b1; n.pc = mm.tgt;
      end else begin
        n.drain_age = mm.drain_age + 1;
      end
    end else if (trap_valid || trap_return_valid) begin
      n.tgt = trap_valid ? model_trap_pc() : model_xret_pc();
      if (mem_idle) begin
        n.redirecting = 1'b1; n.rv = 1'b1; n.pc = n.tgt;
      end else begin
        n.draining = 1'b1; n.drain_age = 0;
      end
    end else begin
      k = oldest_flush();
      if (k >= 0) begin
        n.tgt = flush_target[k*AW +: AW];
        n.redirecting = 1'b1; n.rv = 1'b1; n.pc = n.tgt;
      end
    end
    return n;
  endfunction

  always @(negedge clk) begin
    logic [NS-1:0] es, ef;
    if (model_on) begin
      for (int d = 0; d < 2; d++) begin
        expect_comb(m[d], es, ef);
        check($sformatf("dut%0d.stall", d), 64'(o_stall[d]), 64'(es));
        check($sformatf("dut%0d.flush", d), 64'(o_flush[d]), 64'(ef));
        check($sformatf("dut%0d.busy", d), 64'(o_busy[d]), 64'(m[d].draining || m[d].redirecting));
        check($sformatf("dut%0d.redirect_valid", d), 64'(o_rv[d]), 64'(m[d].rv));
        check($sformatf("dut%0d.redirect_pc", d), 64'(o_pc[d]), 64'(m[d].pc));
        check($sformatf("dut%0d.timeout_error", d), 64'(o_terr[d]), 64'(m[d].terr));
      end
    end
    if (rst) begin
      m[0] = model_reset();
      m[1] = model_reset();
      model_on = 1'b1;
    end else if (model_on) begin
      for (int d = 0; d < 2; d++) m[d] = model_next(m[d], tmo_of(d));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    stall_req = '0;
    flush_req = '0;
    trap_valid = 1'b0;
    trap_return_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    mem_idle = 1'b1;
    flush_target = '0;
    trap_is_interrupt = 1'b0;
    trap_code = '0;
    next_priv = 2'd0;
    trap_return_priv = 2'd0;
    mtvec = '0; stvec = '0; utvec = '0;
    mepc = '0; sepc = '0; uepc = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset.busy", 64'(o_busy[d]), 64'd0);
      check("reset.redirect_valid", 64'(o_rv[d]), 64'd0);
      check("reset.redirect_pc", 64'(o_pc[d]), 64'd0);
      check("reset.timeout_error", 64'(o_terr[d]), 64'd0);
    end
    tick();

    // Stall propagates to all younger stages.
    stall_req = 6'b000100;
    @(negedge clk);
    check("stall_chain.stall", 64'(o_stall[0]), 64'h07);
    check("stall_chain.flush", 64'(o_flush[0]), 64'h00);
    check("stall_chain.busy", 64'(o_busy[0]), 64'd0);
    tick();

    // Oldest flush request wins and keeps its own stage.
    clear_reqs();
    flush_req = 6'b001010;
    flush_target[3*AW +: AW] = 32'h0000_0100;
    flush_target[1*AW +: AW] = 32'h0000_0200;
    @(negedge clk);
    check("flush_req.flush", 64'(o_flush[0]), 64'h07);
    tick();
    clear_reqs();
    @(negedge clk);
    check("flush_req.redirect_valid", 64'(o_rv[0]), 64'd1);
    check("flush_req.redirect_pc", 64'(o_pc[0]), 64'h100);
    check("flush_req.redirect_flush", 64'(o_flush[0]), 64'h3F);
    tick();
    @(negedge clk);
    check("flush_req.back_idle", 64'(o_busy[0]), 64'd0);
    tick();

    // Vectored interrupt into M mode, memory idle.
    trap_valid = 1'b1; trap_is_interrupt = 1'b1; trap_code = 5'd7; next_priv = 2'd3;
    mtvec = 32'h8000_0001; mem_idle = 1'b1;
    @(negedge clk);
    check("trap_int.flush", 64'(o_flush[0]), 64'h3F);
    check("trap_int.stall", 64'(o_stall[0]), 64'h00);
    tick();
    clear_reqs();
    @(negedge clk);
    check("trap_int.redirect_valid", 64'(o_rv[0]), 64'd1);
    check("trap_int.redirect_pc", 64'(o_pc[0]), 64'h8000_001C);
    tick();

    // Exception with outstanding memory ops: drain, then redirect after mem_idle rises.
    trap_valid = 1'b1; trap_is_interrupt = 1'b0; next_priv = 2'd1;
    stvec = 32'h4000_0101; mem_idle = 1'b0;
    @(negedge clk);
    check("trap_drain.flush", 64'(o_flush[0]), 64'h3F);
    tick();
    clear_reqs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("trap_drain.stall", 64'(o_stall[0]), 64'h3F);
      check("trap_drain.no_redirect", 64'(o_rv[0]), 64'd0);
      tick();
    end
    mem_idle = 1'b1;
    @(negedge clk);
    check("trap_drain.last_stall", 64'(o_stall[0]), 64'h3F);
    tick();
    @(negedge clk);
    check("trap_drain.redirect_valid", 64'(o_rv[0]), 64'd1);
    check("trap_drain.redirect_pc", 64'(o_pc[0]), 64'h4000_0100);
    tick();

    // Drain timeout on the DRAIN_TIMEOUT=4 instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("timeout.cleared_by_rst", 64'(o_terr[1]), 64'd0);
    tick();
    trap_valid = 1'b1; trap_is_interrupt = 1'b0; next_priv = 2'd3;
    mtvec = 32'h0000_2000; mem_idle = 1'b0;
    @(negedge clk);
    check("timeout.flush", 64'(o_flush[1]), 64'h3F);
    tick();
    clear_reqs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("timeout.drain_stall", 64'(o_stall[1]), 64'h3F);
      check("timeout.no_redirect", 64'(o_rv[1]), 64'd0);
      tick();
    end
    @(negedge clk);
    check("timeout.redirect_valid", 64'(o_rv[1]), 64'd1);
    check("timeout.redirect_pc", 64'(o_pc[1]), 64'h2000);
    check("timeout.error_set", 64'(o_terr[1]), 64'd1);
    tick();
    @(negedge clk);
    check("timeout.idle_again", 64'(o_busy[1]), 64'd0);
    check("timeout.long_drain_busy", 64'(o_busy[0]), 64'd1);
    tick();
    mem_idle = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    check("timeout.error_sticky", 64'(o_terr[1]), 64'd1);
    check("timeout.long_drain_done", 64'(o_busy[0]), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("timeout.error_cleared", 64'(o_terr[1]), 64'd0);
    tick();

    // Trap beats a simultaneous flush request.
    trap_valid = 1'b1; trap_is_interrupt = 1'b1; next_priv = 2'd3; mtvec = 32'h0000_1000;
    flush_req = 6'b010000; flush_target[4*AW +: AW] = 32'hDEAD_0000; mem_idle = 1'b1;
    @(negedge clk);
    check("trap_vs_flush.flush", 64'(o_flush[0]), 64'h3F);
    tick();
    clear_reqs();
    @(negedge clk);
    check("trap_vs_flush.redirect_pc", 64'(o_pc[0]), 64'h1000);
    tick();

    // xRET with the reserved privilege falls back to uepc.
    trap_return_valid = 1'b1; trap_return_priv = 2'd2;
    uepc = 32'h0000_1234; mepc = 32'h0000_5678;
    tick();
    clear_reqs();
    @(negedge clk);
    check("xret.redirect_pc", 64'(o_pc[0]), 64'h1234);
    tick();

    // Reset in the middle of a drain.
    trap_valid = 1'b1; trap_is_interrupt = 1'b0; mem_idle = 1'b0;
    tick();
    clear_reqs();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_drain.busy_before", 64'(o_busy[0]), 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_drain.busy", 64'(o_busy[0]), 64'd0);
    check("rst_in_drain.stall", 64'(o_stall[0]), 64'h00);
    check("rst_in_drain.flush", 64'(o_flush[0]), 64'h00);
    check("rst_in_drain.redirect_valid", 64'(o_rv[0]), 64'd0);
    check("rst_in_drain.redirect_pc", 64'(o_pc[0]), 64'd0);
    tick();

    // Randomized traffic; the compare process checks every cycle.
    begin
      int bias = 6;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc % 50 == 0) bias = $urandom_range(1, 7);
        stall_req = NS'($urandom);
        flush_req = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
        for (int i = 0; i < NS; i++) flush_target[i*AW +: AW] = $urandom;
        trap_valid        = ($urandom_range(0, 9) == 0);
        trap_is_interrupt = 1'($urandom_range(0, 1));
        trap_code         = CAUSE_WIDTH'($urandom);
        next_priv         = 2'($urandom);
        trap_return_valid = ($urandom_range(0, 9) == 0);
        trap_return_priv  = 2'($urandom);
        mtvec = $urandom; stvec = $urandom; utvec = $urandom;
        mepc  = $urandom; sepc  = $urandom; uepc  = $urandom;
        mem_idle = ($urandom_range(0, 7) < bias);
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    rst = 1'b0;
    clear_reqs();
    mem_idle = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
